// File: rtl/alu_seq.sv
// Handshaked sequential ALU: add, subtract, shift-add multiply and optional multiply-accumulate.
// Define ALU_ACC_EN to add the 2*WIDTH accumulator, the acc_clr port and the MAC opcode.
//
// state  | meaning
// S_IDLE | waiting for an operand beat; ADD/SUB complete here in one edge
// S_MUL  | one multiplier bit consumed per cycle, WIDTH cycles total
// S_DONE | product (or accumulated sum) written to the result buffer
module alu_seq #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_c,
   output logic [1:0]         out_op
`ifdef ALU_ACC_EN
   ,
   input  logic               acc_clr
`endif
);

   localparam int RW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   logic [CW-1:0]    cnt;
   logic [RW-1:0]    mcand;
   logic [WIDTH-1:0] mplier;
   logic [RW-1:0]    partial;
   logic [1:0]       op_reg;

   logic             accept;
   logic             load_alu;
   logic             load_mul;
   logic             mul_step;
   logic             mul_done;
   logic [WIDTH:0]   alu_res;
   logic [RW-1:0]    mul_res;

`ifdef ALU_ACC_EN
   logic [RW-1:0]    acc;
   logic             mac_done;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept && in_op[1]) state_nxt = S_MUL;
         S_MUL:  if (cnt == '0) state_nxt = S_DONE;
         S_DONE: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      mul_step = 1'b0;
      mul_done = 1'b0;
      case (state)
         S_IDLE: in_ready = !rst && (!out_valid || out_ready);
         S_MUL:  mul_step = 1'b1;
         S_DONE: mul_done = 1'b1;
         default: ;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign load_alu = accept && !in_op[1];
   assign load_mul = accept && in_op[1];

   // The extra top bit of a WIDTH+1 bit subtraction is exactly the borrow.
   assign alu_res = in_op[0] ? ({1'b0, in_a} - {1'b0, in_b})
                             : ({1'b0, in_a} + {1'b0, in_b});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         partial <= '0;
         op_reg  <= '0;
      end else if (load_mul) begin
         cnt     <= CW'(WIDTH - 1);
         mcand   <= {{WIDTH{1'b0}}, in_a};
         mplier  <= in_b;
         partial <= '0;
         op_reg  <= in_op;
      end else if (mul_step) begin
         if (mplier[0]) partial <= partial + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 1'b1;
      end
   end

`ifdef ALU_ACC_EN
   assign mac_done = mul_done && (op_reg == 2'd3);

   always_comb begin
      mul_res = partial;
      if (mac_done && !acc_clr) mul_res = acc + partial;
   end

   // A clear landing on the MAC completion edge restarts the sum from this product.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (mac_done) begin
         acc <= mul_res;
      end else if (acc_clr) begin
         acc <= '0;
      end
   end
`else
   assign mul_res = partial;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_c     <= '0;
         out_op    <= '0;
      end else if (load_alu) begin
         out_valid <= 1'b1;
         out_c     <= {{(WIDTH-1){1'b0}}, alu_res};
         out_op    <= in_op;
      end else if (mul_done) begin
         out_valid <= 1'b1;
         out_c     <= mul_res;
         out_op    <= op_reg;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vector table, hand-built corner
// sequences and a randomized run against an arithmetic reference model.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic [1:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_c;
   logic [1:0]  out_op;
`ifdef ALU_ACC_EN
   logic        acc_clr;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   int m_acc    = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_c     (out_c),
      .out_op    (out_op)
`ifdef ALU_ACC_EN
      ,
      .acc_clr   (acc_clr)
`endif
   );

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] c;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Result of one operation from the arithmetic rules; MAC also advances the model accumulator.
   function automatic int model(input int op, input int a, input int b);
      int r;
      case (op)
         0: r = a + b;
         1: r = (a >= b) ? (a - b) : (a - b + 512);
         2: r = a * b;
         default: begin
`ifdef ALU_ACC_EN
            m_acc = (m_acc + a * b) % 65536;
            r = m_acc;
`else
            r = a * b;
`endif
         end
      endcase
      return r;
   endfunction

   // lat = edges after the accept edge until out_valid is seen (ADD/SUB register on the accept edge).
   task automatic do_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int clr_at, output logic [15:0] c, output logic [1:0] o,
                        output int lat);
      int busy_ready;
      chk("in_ready_before_op", in_ready, 1);
      in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      busy_ready = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ready++;
         in_a  = 8'($urandom);
         in_b  = 8'($urandom);
         in_op = 2'($urandom);
`ifdef ALU_ACC_EN
         acc_clr = (lat + 1 == clr_at);
`endif
         @(posedge clk); #1;
         lat++;
      end
`ifdef ALU_ACC_EN
      acc_clr = 1'b0;
`endif
      if (lat >= 40) chk("result_timeout", 0, 1);
      c = out_c;
      o = out_op;
      if (op[1]) chk("in_ready_low_while_busy", busy_ready, 0);
   endtask

   vec_t        tbl[$];
   logic [15:0] c;
   logic [15:0] c_hold;
   logic [1:0]  o;
   int          lat;
   int          stray;
   int          e;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
`ifdef ALU_ACC_EN
      acc_clr = 1'b0;
`endif
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_c", out_c, 0);
      chk("rst_out_op", out_op, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      tbl.push_back('{2'd0, 8'hFF, 8'h01, 16'h0100, 0});
      tbl.push_back('{2'd1, 8'h05, 8'h07, 16'h01FE, 0});
      tbl.push_back('{2'd1, 8'h07, 8'h05, 16'h0002, 0});
      tbl.push_back('{2'd2, 8'hFF, 8'hFF, 16'hFE01, 9});
      tbl.push_back('{2'd0, 8'h00, 8'h00, 16'h0000, 0});
      tbl.push_back('{2'd1, 8'h00, 8'hFF, 16'h0101, 0});
      tbl.push_back('{2'd2, 8'h80, 8'h02, 16'h0100, 9});
      tbl.push_back('{2'd2, 8'h00, 8'hFF, 16'h0000, 9});
`ifdef ALU_ACC_EN
      tbl.push_back('{2'd3, 8'h10, 8'h10, 16'h0100, 9});
      tbl.push_back('{2'd3, 8'h10, 8'h10, 16'h0200, 9});
      tbl.push_back('{2'd3, 8'h10, 8'h10, 16'h0300, 9});
`else
      tbl.push_back('{2'd3, 8'h10, 8'h10, 16'h0100, 9});
      tbl.push_back('{2'd3, 8'h10, 8'h10, 16'h0100, 9});
      tbl.push_back('{2'd3, 8'h10, 8'h10, 16'h0100, 9});
`endif
      foreach (tbl[i]) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, -1, c, o, lat);
         chk($sformatf("tbl%0d_c", i), c, tbl[i].c);
         chk($sformatf("tbl%0d_op", i), o, tbl[i].op);
         chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      end
`ifdef ALU_ACC_EN
      m_acc = 16'h0300;
`endif

      // Backpressure: result held 5 cycles, pending beat refused, then drain and accept on one edge.
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; in_op = 2'd0; in_a = 8'h3C; in_b = 8'h0F;
      @(posedge clk); #1;
      chk("bp_first_valid", out_valid, 1);
      chk("bp_first_c", out_c, 16'h004B);
      in_op = 2'd1; in_a = 8'h01; in_b = 8'h02;
      for (int k = 0; k < 5; k++) begin
         chk("bp_in_ready_low", in_ready, 0);
         @(posedge clk); #1;
         chk("bp_out_c_stable", out_c, 16'h004B);
         chk("bp_out_valid_held", out_valid, 1);
      end
      out_ready = 1'b1;
      #1 chk("bp_release_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_second_valid", out_valid, 1);
      chk("bp_second_c", out_c, 16'h01FF);
      chk("bp_second_op", out_op, 2'd1);
      @(posedge clk); #1;
      chk("bp_drained", out_valid, 0);

      // Back-to-back ADD/SUB: one result per cycle.
      for (int k = 0; k < 6; k++) begin
         in_valid = 1'b1;
         in_op = 2'(k % 2);
         in_a = 8'($urandom);
         in_b = 8'($urandom);
         e = model(int'(in_op), int'(in_a), int'(in_b));
         chk("b2b_in_ready", in_ready, 1);
         @(posedge clk); #1;
         chk("b2b_valid", out_valid, 1);
         chk("b2b_c", out_c, e);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("b2b_drained", out_valid, 0);

      // Reset during the 4th multiply cycle: nothing from the aborted op may appear.
      in_valid = 1'b1; in_op = 2'd2; in_a = 8'hAB; in_b = 8'hCD;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_out_c", out_c, 0);
      @(posedge clk); #1 rst = 1'b0;
      #1 chk("mid_rst_release_in_ready", in_ready, 1);
      m_acc = 0;
      stray = 0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         if (out_valid) stray++;
      end
      chk("mid_rst_no_stale_result", stray, 0);

`ifdef ALU_ACC_EN
      do_op(2'd3, 8'h10, 8'h10, -1, c, o, lat);
      chk("mac_after_rst", c, 16'h0100);
      acc_clr = 1'b1;
      @(posedge clk); #1;
      acc_clr = 1'b0;
      do_op(2'd3, 8'h02, 8'h03, -1, c, o, lat);
      chk("mac_after_clr", c, 16'h0006);
      do_op(2'd3, 8'h05, 8'h05, 9, c, o, lat);
      chk("mac_clr_at_done", c, 16'h0019);
      do_op(2'd3, 8'h01, 8'h01, -1, c, o, lat);
      chk("mac_after_clr_at_done", c, 16'h001A);
      m_acc = 16'h001A;
`endif

      for (int k = 0; k < 60; k++) begin
         logic [1:0] rop;
         logic [7:0] ra;
         logic [7:0] rb;
         rop = 2'($urandom_range(0, 3));
         ra  = 8'($urandom);
         rb  = 8'($urandom);
         e = model(int'(rop), int'(ra), int'(rb));
         do_op(rop, ra, rb, -1, c, o, lat);
         chk($sformatf("rnd%0d_c", k), c, e);
         chk($sformatf("rnd%0d_op", k), o, rop);
         chk($sformatf("rnd%0d_lat", k), lat, rop[1] ? 9 : 0);
      end

      @(posedge clk); #1;
      chk("final_drained", out_valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
